// File: rtl/rida_pkg.sv
// Shared types and constants for the RIDA 27-bit decode stage.
package rida_pkg;

  localparam int unsigned XLEN = 27;

  localparam int unsigned OP_HI  = 26;
  localparam int unsigned OP_LO  = 22;
  localparam int unsigned RD_HI  = 21;
  localparam int unsigned RD_LO  = 17;
  localparam int unsigned RS1_HI = 16;
  localparam int unsigned RS1_LO = 12;
  localparam int unsigned RS2_HI = 11;
  localparam int unsigned RS2_LO = 7;
  localparam int unsigned IMM12_W = 12;
  localparam int unsigned IMM17_W = 17;

  typedef enum logic [4:0] {
    OpNop  = 5'b00000,
    OpAdd  = 5'b00001,
    OpSub  = 5'b00010,
    OpAnd  = 5'b00011,
    OpOr   = 5'b00100,
    OpXor  = 5'b00101,
    OpSll  = 5'b00110,
    OpSrl  = 5'b00111,
    OpAddi = 5'b01001,
    OpAndi = 5'b01011,
    OpOri  = 5'b01100,
    OpXori = 5'b01101,
    OpLw   = 5'b10000,
    OpSw   = 5'b10001,
    OpBeq  = 5'b11000,
    OpBne  = 5'b11001,
    OpJmp  = 5'b11100
  } opcode_e;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6
  } alu_ctl_e;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] result_src;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [3:0] alu_ctl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // ALU operation implied by an opcode; loads/stores/jumps fall through to ADD.
  function automatic logic [3:0] alu_for_op(opcode_e op);
    logic [3:0] alu;
    case (op)
      OpSub, OpBeq, OpBne: alu = AluSub;
      OpAnd, OpAndi:       alu = AluAnd;
      OpOr, OpOri:         alu = AluOr;
      OpXor, OpXori:       alu = AluXor;
      OpSll:               alu = AluSll;
      OpSrl:               alu = AluSrl;
      default:             alu = AluAdd;
    endcase
    return alu;
  endfunction

  function automatic logic [XLEN-1:0] sext12(logic [IMM12_W-1:0] imm);
    return {{(XLEN - IMM12_W){imm[IMM12_W-1]}}, imm};
  endfunction

  function automatic logic [XLEN-1:0] sext17(logic [IMM17_W-1:0] imm);
    return {{(XLEN - IMM17_W){imm[IMM17_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// NREG x DATA_W register file: two async reads, one sync write, async clear, r0 hardwired to 0.
// Define RIDA_RF_BYPASS_EN to forward a same-cycle write to the read ports.
module register_file #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned NREG   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [$clog2(NREG)-1:0] i_ra1,
  input  logic [$clog2(NREG)-1:0] i_ra2,
  output logic [DATA_W-1:0]       o_rd1,
  output logic [DATA_W-1:0]       o_rd2,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_wa,
  input  logic [DATA_W-1:0]       i_wd
);

  logic [DATA_W-1:0] r_mem [NREG];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_wa != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
`ifdef RIDA_RF_BYPASS_EN
    // Write-through: readers see the value being written this cycle.
    if (w_wr_en && (i_wa == i_ra1)) o_rd1 = i_wd;
    if (w_wr_en && (i_wa == i_ra2)) o_rd2 = i_wd;
`else
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RIDA ID stage: decode, register read, immediate extension, load-use stall, ID/EX register.
// Register-file write-through is enabled by defining RIDA_RF_BYPASS_EN.
module decode_stage
  import rida_pkg::*;
#(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] InstrD,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [4:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              StallD,
  output ctrl_t             CtrlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [4:0]        RdE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic              IllegalE
);

  opcode_e           w_op;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_a2;
  ctrl_t             w_ctrl;
  logic              w_illegal;
  logic [DATA_W-1:0] w_imm;
  logic              w_use_rs1;
  logic              w_use_p2;
  logic              w_p2_is_rd;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_hazard;
  logic              w_bubble;

  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_pc4;
  logic              r_illegal;

  assign w_op  = opcode_e'(InstrD[OP_HI:OP_LO]);
  assign w_rd  = InstrD[RD_HI:RD_LO];
  assign w_rs1 = InstrD[RS1_HI:RS1_LO];
  assign w_rs2 = InstrD[RS2_HI:RS2_LO];
  // Stores and branches read their second operand through the rd field.
  assign w_a2  = w_p2_is_rd ? w_rd : w_rs2;

  always_comb begin
    w_ctrl     = CTRL_BUBBLE;
    w_illegal  = 1'b0;
    w_imm      = '0;
    w_use_rs1  = 1'b0;
    w_use_p2   = 1'b0;
    w_p2_is_rd = 1'b0;
    unique case (w_op)
      OpNop: ;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctl   = alu_for_op(w_op);
        w_use_rs1        = 1'b1;
        w_use_p2         = 1'b1;
      end
      OpAddi, OpAndi, OpOri, OpXori: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctl   = alu_for_op(w_op);
        w_imm            = sext12(InstrD[IMM12_W-1:0]);
        w_use_rs1        = 1'b1;
      end
      OpLw: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_ctl    = AluAdd;
        w_imm             = sext12(InstrD[IMM12_W-1:0]);
        w_use_rs1         = 1'b1;
      end
      OpSw: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctl   = AluAdd;
        w_imm            = sext12(InstrD[IMM12_W-1:0]);
        w_use_rs1        = 1'b1;
        w_use_p2         = 1'b1;
        w_p2_is_rd       = 1'b1;
      end
      OpBeq, OpBne: begin
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = (w_op == OpBne);
        w_ctrl.alu_ctl   = alu_for_op(w_op);
        w_imm            = sext12(InstrD[IMM12_W-1:0]);
        w_use_rs1        = 1'b1;
        w_use_p2         = 1'b1;
        w_p2_is_rd       = 1'b1;
      end
      OpJmp: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm             = sext17(InstrD[IMM17_W-1:0]);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  register_file #(
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) u_rf (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_ra1  (w_rs1),
    .i_ra2  (w_a2),
    .o_rd1  (w_rd1),
    .o_rd2  (w_rd2),
    .i_we   (RegWriteW),
    .i_wa   (RdW),
    .i_wd   (ResultW)
  );

  assign w_hazard = r_ctrl.mem_read && (r_rd != '0) &&
                    ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_p2 && (w_a2 == r_rd)));
  assign StallD   = w_hazard && !FlushE;
  assign w_bubble = FlushE || w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pc      <= '0;
      r_pc4     <= '0;
      r_illegal <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pc      <= '0;
      r_pc4     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_rd1     <= w_rd1;
      r_rd2     <= w_rd2;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_a2;
      r_pc      <= PCD;
      r_pc4     <= PCPlus4D;
      r_illegal <= w_illegal;
    end
  end

  assign CtrlE    = r_ctrl;
  assign RD1E     = r_rd1;
  assign RD2E     = r_rd2;
  assign ImmExtE  = r_imm;
  assign RdE      = r_rd;
  assign Rs1E     = r_rs1;
  assign Rs2E     = r_rs2;
  assign PCE      = r_pc;
  assign PCPlus4E = r_pc4;
  assign IllegalE = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued at drive time.
module tb_decode_stage;
  import rida_pkg::*;

  localparam int OW = 164;
  localparam logic [OW-1:0] M_ALL = '1;
  localparam logic [OW-1:0] M_CTL = {13'h1fff, 150'b0, 1'b1};

  localparam logic [4:0] O_NOP = 5'b00000, O_ADD = 5'b00001, O_SUB = 5'b00010;
  localparam logic [4:0] O_ADDI = 5'b01001, O_LW = 5'b10000, O_SW = 5'b10001;
  localparam logic [4:0] O_BEQ = 5'b11000, O_BNE = 5'b11001, O_JMP = 5'b11100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        FlushE = 1'b0, RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic        StallD, IllegalE;
  ctrl_t       CtrlE;
  logic [26:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  typedef struct {
    logic [OW-1:0] val;
    logic [OW-1:0] msk;
    string         name;
  } sb_t;

  sb_t sb[$];
  int  n_total = 0;
  int  n_pass  = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .StallD(StallD), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic ctrl_t mkc(logic rw, logic mw, logic mr, logic [1:0] rs, logic as,
                                logic br, logic bn, logic j, logic [3:0] alu);
    ctrl_t c;
    c.reg_write = rw; c.mem_write = mw; c.mem_read = mr; c.result_src = rs;
    c.alu_src = as; c.branch = br; c.branch_ne = bn; c.jump = j; c.alu_ctl = alu;
    return c;
  endfunction

  function automatic logic [OW-1:0] ev(ctrl_t c, logic [26:0] d1, logic [26:0] d2,
                                       logic [26:0] im, logic [4:0] rd, logic [4:0] r1,
                                       logic [4:0] r2, logic [26:0] pc, logic [26:0] pc4,
                                       logic il);
    return {c, d1, d2, im, rd, r1, r2, pc, pc4, il};
  endfunction

  function automatic logic [OW-1:0] out_vec();
    return {CtrlE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E, IllegalE};
  endfunction

  function automatic logic [26:0] fr(logic [4:0] op, logic [4:0] rd, logic [4:0] r1,
                                     logic [4:0] r2);
    return {op, rd, r1, r2, 7'b0};
  endfunction

  function automatic logic [26:0] fi(logic [4:0] op, logic [4:0] rd, logic [4:0] r1,
                                     logic [11:0] imm);
    return {op, rd, r1, imm};
  endfunction

  task automatic push(string nm, logic [OW-1:0] v, logic [OW-1:0] m);
    sb_t s;
    s.val = v; s.msk = m; s.name = nm;
    sb.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [26:0] instr, logic [26:0] pc);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 27'd4;
  endtask

  task automatic wb(logic [4:0] rd, logic [26:0] data);
    drv('0, '0);
    RegWriteW = 1'b1; RdW = rd; ResultW = data;
    cyc();
    RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    drv(fr(O_ADD, 5'd4, 5'd3, 5'd3), 27'h40);
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (out_vec() !== '0) $display("FAIL reset_async: got %h, expected 0", out_vec());
    else n_pass++;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL reset_stall: got %b, expected 0", StallD);
    else n_pass++;
    cyc();
    n_total++;
    if (out_vec() !== '0) $display("FAIL reset_held: got %h, expected 0", out_vec());
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_addi();
    sb_t e;
    drv(fi(O_ADDI, 5'd1, 5'd0, 12'hFFF), 27'h100);
    push("addi_neg1", ev(mkc(1, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 27'h7FFFFFF, 1, 0, 31,
                         27'h100, 27'h104, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  task automatic test_rtype();
    sb_t e;
    logic [3:0] alu_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    wb(5'd3, 27'h0000123);
    wb(5'd2, 27'h00002AA);
    for (int i = 0; i < 7; i++) begin
      logic [4:0] op;
      op = 5'(i + 1);
      drv(fr(op, 5'd4, 5'd3, 5'd2), 27'h200 + 27'(4 * i));
      push($sformatf("rtype_op%0d", i + 1),
           ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, alu_tab[i]), 27'h123, 27'h2AA, 0, 4, 3, 2,
              27'h200 + 27'(4 * i), 27'h204 + 27'(4 * i), 0), M_ALL);
      cyc();
      e = sb.pop_front();
      n_total++;
      if ((out_vec() & e.msk) !== (e.val & e.msk))
        $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
      else n_pass++;
    end
    drv(fr(O_ADD, 5'd4, 5'd3, 5'd3), 27'h300);
    push("add_r3_r3", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 0), 27'h123, 27'h123, 0, 4, 3, 3,
                         27'h300, 27'h304, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  task automatic test_itype();
    sb_t e;
    logic [4:0] op_tab  [3] = '{5'b01011, 5'b01100, 5'b01101};
    logic [3:0] alu_tab [3] = '{4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 3; i++) begin
      drv(fi(op_tab[i], 5'd6, 5'd3, 12'h801), 27'h400);
      push($sformatf("itype_%0d", i),
           ev(mkc(1, 0, 0, 0, 1, 0, 0, 0, alu_tab[i]), 27'h123, 0, 27'h7FFF801, 6, 3, 16,
              27'h400, 27'h404, 0), M_ALL);
      cyc();
      e = sb.pop_front();
      n_total++;
      if ((out_vec() & e.msk) !== (e.val & e.msk))
        $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    sb_t e;
    drv('0, '0);
    cyc();
    drv(fi(O_LW, 5'd5, 5'd1, 12'h004), 27'h500);
    push("lw_r5", ev(mkc(1, 0, 1, 1, 1, 0, 0, 0, 0), 0, 0, 27'h4, 5, 1, 0,
                     27'h500, 27'h504, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv(fr(O_SUB, 5'd6, 5'd5, 5'd2), 27'h504);
    #1;
    n_total++;
    if (StallD !== 1'b1) $display("FAIL stall_rs1: got %b, expected 1", StallD);
    else n_pass++;
    push("stall_bubble", '0, M_CTL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL stall_released: got %b, expected 0", StallD);
    else n_pass++;
    push("sub_after_stall", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 1), 0, 27'h2AA, 0, 6, 5, 2,
                               27'h504, 27'h508, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    // Store data read via rd field must also trigger the interlock.
    drv(fi(O_LW, 5'd3, 5'd1, 12'h000), 27'h600);
    cyc();
    drv(fi(O_SW, 5'd3, 5'd1, 12'h000), 27'h604);
    #1;
    n_total++;
    if (StallD !== 1'b1) $display("FAIL stall_port2: got %b, expected 1", StallD);
    else n_pass++;
    drv('0, '0);
    cyc();
    drv(fi(O_LW, 5'd5, 5'd1, 12'h000), 27'h700);
    cyc();
    drv(fi(O_ADDI, 5'd6, 5'd0, 12'h280), 27'h704);
    #1;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL no_stall_unused_rs2: got %b, expected 0", StallD);
    else n_pass++;
    cyc();
    drv(fi(O_LW, 5'd0, 5'd1, 12'h000), 27'h708);
    cyc();
    drv(fr(O_ADD, 5'd4, 5'd0, 5'd0), 27'h70C);
    #1;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL no_stall_r0: got %b, expected 0", StallD);
    else n_pass++;
    cyc();
  endtask

  task automatic test_flush();
    sb_t e;
    drv(fi(O_LW, 5'd5, 5'd1, 12'h004), 27'h800);
    cyc();
    drv(fr(O_SUB, 5'd6, 5'd5, 5'd2), 27'h804);
    FlushE = 1'b1;
    #1;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL flush_stall: got %b, expected 0", StallD);
    else n_pass++;
    push("flush_bubble", '0, M_CTL);
    cyc();
    FlushE = 1'b0;
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  task automatic test_sw_branch_jmp();
    sb_t e;
    logic [OW-1:0] jm;
    wb(5'd7, 27'h0000777);
    wb(5'd8, 27'h0000088);
    drv(fi(O_SW, 5'd7, 5'd8, 12'h00C), 27'h900);
    push("sw", ev(mkc(0, 1, 0, 0, 1, 0, 0, 0, 0), 27'h88, 27'h777, 27'hC, 7, 8, 7,
                  27'h900, 27'h904, 0), M_ALL);
    drv(fi(O_SW, 5'd7, 5'd8, 12'h00C), 27'h900);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv(fi(O_BEQ, 5'd3, 5'd8, 12'hFF8), 27'h904);
    push("beq", ev(mkc(0, 0, 0, 0, 0, 1, 0, 0, 1), 27'h88, 27'h123, 27'h7FFFFF8, 3, 8, 3,
                   27'h904, 27'h908, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv(fi(O_BNE, 5'd3, 5'd8, 12'h010), 27'h908);
    push("bne", ev(mkc(0, 0, 0, 0, 0, 0, 1, 0, 1), 27'h88, 27'h123, 27'h10, 3, 8, 3,
                   27'h908, 27'h90C, 0), M_ALL & ~(164'b1 << 157));
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv({O_JMP, 5'd1, 17'h10000}, 27'h90C);
    jm = ev('1, 0, 0, '1, '1, 0, 0, '1, '1, 1'b1);
    push("jmp", ev(mkc(1, 0, 0, 2, 0, 0, 0, 1, 0), 0, 0, 27'h7FF0000, 1, 0, 0,
                   27'h90C, 27'h910, 0), jm);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  task automatic test_illegal();
    sb_t e;
    logic [4:0] op_tab [5] = '{5'b11111, 5'b01000, 5'b01010, 5'b11101, 5'b00000};
    logic       il_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drv(fi(op_tab[i], 5'd3, 5'd3, 12'h0FF), 27'hA00);
      push($sformatf("opcode_%b", op_tab[i]),
           ev('0, 0, 0, 0, 0, 0, 0, 0, 0, il_tab[i]), M_CTL);
      cyc();
      e = sb.pop_front();
      n_total++;
      if ((out_vec() & e.msk) !== (e.val & e.msk))
        $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    sb_t e;
    logic [26:0] same_cycle;
`ifdef RIDA_RF_BYPASS_EN
    same_cycle = 27'h55;
`else
    same_cycle = 27'h11;
`endif
    wb(5'd9, 27'h11);
    drv(fr(O_ADD, 5'd10, 5'd9, 5'd0), 27'hB00);
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 27'h55;
    push("rf_same_cycle", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 0), same_cycle, 0, 0, 10, 9, 0,
                             27'hB00, 27'hB04, 0), M_ALL);
    cyc();
    RegWriteW = 1'b0;
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv(fr(O_ADD, 5'd11, 5'd0, 5'd9), 27'hB04);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 27'h3FF;
    push("rf_after_write", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 27'h55, 0, 11, 0, 9,
                              27'hB04, 27'hB08, 0), M_ALL);
    cyc();
    RegWriteW = 1'b0;
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
    drv(fr(O_ADD, 5'd11, 5'd0, 5'd0), 27'hB08);
    push("r0_ignores_write", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 11, 0, 0,
                                27'hB08, 27'hB0C, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    sb_t e;
    drv(fi(O_LW, 5'd5, 5'd1, 12'h004), 27'hC00);
    cyc();
    drv(fr(O_SUB, 5'd6, 5'd5, 5'd2), 27'hC04);
    #1;
    n_total++;
    if (StallD !== 1'b1) $display("FAIL pre_reset_stall: got %b, expected 1", StallD);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (out_vec() !== '0) $display("FAIL mid_reset_outputs: got %h, expected 0", out_vec());
    else n_pass++;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL mid_reset_stall: got %b, expected 0", StallD);
    else n_pass++;
    cyc();
    rst = 1'b1;
    #1;
    n_total++;
    if (StallD !== 1'b0) $display("FAIL post_reset_stall: got %b, expected 0", StallD);
    else n_pass++;
    drv(fr(O_ADD, 5'd4, 5'd3, 5'd3), 27'hD00);
    push("rf_cleared", ev(mkc(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 4, 3, 3,
                          27'hD00, 27'hD04, 0), M_ALL);
    cyc();
    e = sb.pop_front();
    n_total++;
    if ((out_vec() & e.msk) !== (e.val & e.msk))
      $display("FAIL %s: got %h, expected %h", e.name, out_vec() & e.msk, e.val & e.msk);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    cyc();
    test_addi();
    test_rtype();
    test_itype();
    test_load_use();
    test_flush();
    test_sw_branch_jmp();
    test_illegal();
    test_bypass();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the RIDA 27-bit pipeline; sits directly downstream of Fetch and consumes InstrD/PCD/PCPlus4D.
- Decodes the instruction, reads the 32x27 register file, sign-extends immediates, detects load-use hazards, and registers everything into the ID/EX pipeline register feeding Execute.
- Register-file write port is driven from Writeback.

Parameters:
- DATA_W, 27, datapath and instruction width
- NREG, 32, register count; r0 reads 0, writes to it ignored

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- InstrD  in  27  instruction from Fetch IF/ID register
- PCD  in  27  PC of InstrD
- PCPlus4D  in  27  PCD+4
- FlushE  in  1  branch/jump taken in Execute; bubble into ID/EX
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback register
- ResultW  in  27  writeback data
- StallD  out  1  load-use stall; Fetch holds PC and IF/ID when 1
- CtrlE  out  rida_pkg::ctrl_t  registered control bundle (reg_write, mem_write, mem_read, result_src[1:0], alu_src, branch, branch_ne, jump, alu_ctl[3:0])
- RD1E  out  27  registered rs1 data
- RD2E  out  27  registered port-2 data
- ImmExtE  out  27  registered sign-extended immediate
- RdE, Rs1E, Rs2E  out  5 each  registered register indices (for forwarding)
- PCE, PCPlus4E  out  27 each  registered PC values
- IllegalE  out  1  registered: opcode not in table

Behaviour:
- Fields: op[26:22], rd[21:17], rs1[16:12], rs2[11:7], imm12[11:0], imm17[16:0].
- Opcodes: 00000 NOP; 00001 ADD; 00010 SUB; 00011 AND; 00100 OR; 00101 XOR; 00110 SLL; 00111 SRL; 01001 ADDI; 01011 ANDI; 01100 ORI; 01101 XORI; 10000 LW; 10001 SW; 11000 BEQ; 11001 BNE; 11100 JMP.
- Any other opcode: decoded as NOP (all enables 0) with IllegalE=1.
- alu_ctl values: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6.
  - I-type, LW, SW use ADD/AND/OR/XOR as appropriate with alu_src=1.
  - BEQ/BNE use SUB.
- result_src: 0 ALU, 1 memory (LW), 2 PCPlus4 (JMP link into rd).
- Immediates:
  - I/LW/SW/BEQ/BNE: imm12 sign-extended to 27 bits.
  - JMP: imm17 sign-extended.
  - R-type: ImmExt = 0.
- Read port-2 address: rd field for SW (store data) and BEQ/BNE (compare); rs2 otherwise. Rs2E carries this address.
- Register file:
  - Write on posedge when RegWriteW && RdW!=0.
  - Reads are combinational.
  - r0 always reads 0.
- Latency: one cycle, D inputs to E outputs.
- Load-use hazard: CtrlE.mem_read=1, RdE!=0, and RdE equals rs1 (if used) or the port-2 address (if used).
  - StallD = hazard && !FlushE (combinational).
  - When StallD=1, the ID/EX register loads a bubble.
  - Fetch re-presents the same InstrD next cycle.
- FlushE=1: ID/EX loads a bubble; StallD forced 0. Flush has priority over stall.
- Bubble: all ctrl_t fields 0, IllegalE=0; data/index fields unconstrained (zero preferred).
- Reset (rst=0, asynchronous):
  - All ID/EX outputs 0; StallD=0.
  - Register file cleared to 0.
  - Reset asserted mid-stall: outputs clear immediately, with no residual stall after release.

Optional Feature:
- Macro: RIDA_RF_BYPASS_EN.
- Defined: a read whose address equals RdW while RegWriteW=1 (RdW!=0) returns ResultW in the same cycle (write-through).
- Undefined: the read returns the pre-write stored value. Execute forwarding must then cover a one-cycle-deeper window.

Decomposition:
- rida_pkg holds:
  - opcode_e enum and alu_ctl_e enum
  - ctrl_t packed struct
  - result_src encodings
  - field bit-position localparams
  - NOP/bubble constant CTRL_BUBBLE
- Sub-module register_file (NREG x DATA_W, 2 async read, 1 sync write, async active-low clear), containing the bypass `ifdef.
- Decoder logic and hazard/ID-EX register stay in decode_stage.

Test Plan:
- Reset then InstrD=ADDI r1,r0,-1 (op 01001, imm12=FFF) -> next cycle: CtrlE.reg_write=1, alu_src=1, alu_ctl=0, ImmExtE=7FFFFFF, RdE=1, RD1E=0.
- Write r3=0x0000123 via RegWriteW, then ADD r4,r3,r3 -> RD1E=RD2E=0x0000123, alu_ctl=0, result_src=0.
- LW r5 in E followed by SUB r6,r5,r2 in D -> StallD=1 for one cycle, bubble in E (CtrlE=0), SUB appears in E the following cycle.
- Same load-use pattern with FlushE=1 -> StallD=0, bubble in E.
- SW r7,12(r8) -> Rs2E=7, mem_write=1, reg_write=0, ImmExtE=0x000000C.
- Same-cycle write r9=0x55 and read r9:
  - With RIDA_RF_BYPASS_EN -> RD1E=0x55.
  - Without -> old value.
- Opcode 11111 -> IllegalE=1, all control 0.
- Asserting rst mid-stream -> all outputs 0 immediately.
